// File: rtl/piso_4bit.sv
// Free-running parallel-in serial-out shifter: reloads parallel_in every WIDTH
// cycles and streams it out one bit per clock, MSB or LSB first.
module piso_4bit #(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] parallel_in,
  output logic             serial_out,
  output logic             word_start
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    bit_cnt;

  // bit_cnt==0 marks the load edge; otherwise shift toward the output end
  always_ff @(posedge clock) begin
    if (reset) begin
      sreg       <= '0;
      bit_cnt    <= '0;
      word_start <= 1'b0;
    end else if (bit_cnt == '0) begin
      sreg       <= parallel_in;
      bit_cnt    <= (WIDTH == 1) ? '0 : CW'(1);
      word_start <= 1'b1;
    end else begin
      sreg       <= LSB_FIRST ? {1'b0, sreg[WIDTH-1:1]} : {sreg[WIDTH-2:0], 1'b0};
      bit_cnt    <= (bit_cnt == LAST) ? '0 : bit_cnt + CW'(1);
      word_start <= 1'b0;
    end
  end

  assign serial_out = LSB_FIRST ? sreg[0] : sreg[WIDTH-1];

endmodule

// File: tb/tb_piso_4bit.sv
// Scoreboard bench for piso_4bit: MSB-first and LSB-first instances share
// stimulus; a word-level model queues expected (bit, start) pairs per edge.
module tb_piso_4bit;

  localparam int W = 4;

  typedef struct {
    logic so;
    logic ws;
  } exp_t;

  logic         clock = 1'b0;
  logic         reset;
  logic [W-1:0] parallel_in;
  logic         so_m, ws_m, so_l, ws_l;

  int n_chk  = 0;
  int n_pass = 0;

  exp_t exp_m[$], exp_l[$];   // expected output per edge, consumed by monitor
  exp_t buf_m[$], buf_l[$];   // remaining bits of the word in flight

  always #5 clock = ~clock;

  piso_4bit #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_m (
    .clock(clock), .reset(reset), .parallel_in(parallel_in),
    .serial_out(so_m), .word_start(ws_m)
  );

  piso_4bit #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_l (
    .clock(clock), .reset(reset), .parallel_in(parallel_in),
    .serial_out(so_l), .word_start(ws_l)
  );

  // Reference: a word is taken whenever the previous word is fully sent;
  // reset discards whatever is left and forces zero outputs.
  always @(posedge clock) begin
    exp_t e;
    if (reset) begin
      buf_m.delete();
      buf_l.delete();
      e.so = 1'b0; e.ws = 1'b0;
      exp_m.push_back(e);
      exp_l.push_back(e);
    end else begin
      if (buf_m.size() == 0) begin
        for (int k = 0; k < W; k++) begin
          e.ws = (k == 0);
          e.so = parallel_in[W-1-k];
          buf_m.push_back(e);
          e.so = parallel_in[k];
          buf_l.push_back(e);
        end
      end
      exp_m.push_back(buf_m.pop_front());
      exp_l.push_back(buf_l.pop_front());
    end
  end

  task automatic check(input string name, input logic act, input logic req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s t=%0t actual=%b required=%b", name, $time, act, req);
  endtask

  always @(posedge clock) begin
    exp_t em, el;
    #1;
    if (exp_m.size() == 0 || exp_l.size() == 0) begin
      n_chk++;
      $display("FAIL scoreboard_empty t=%0t actual=0 required=1", $time);
    end else begin
      em = exp_m.pop_front();
      el = exp_l.pop_front();
      check("msb_serial_out", so_m, em.so);
      check("msb_word_start", ws_m, em.ws);
      check("lsb_serial_out", so_l, el.so);
      check("lsb_word_start", ws_l, el.ws);
    end
  end

  task automatic step(input logic r, input logic [W-1:0] d);
    reset       = r;
    parallel_in = d;
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1;
    parallel_in = 4'b1111;
    @(negedge clock);
    // reset held for several edges with all-ones input
    repeat (3) step(1'b1, 4'b1111);
    // basic word, then mid-word change to 0110 for the next word
    step(1'b0, 4'b1011);
    step(1'b0, 4'b1011);
    repeat (6) step(1'b0, 4'b0110);
    // reset mid-word after two bits of 1011
    step(1'b0, 4'b1011);
    step(1'b0, 4'b1011);
    step(1'b1, 4'b1011);
    repeat (4) step(1'b0, 4'b1011);
    // all-zero and all-ones words
    repeat (4) step(1'b0, 4'b0000);
    repeat (4) step(1'b0, 4'b1111);
    // random data with occasional resets
    for (int i = 0; i < 2000; i++)
      step(($urandom_range(0, 39) == 0), W'($urandom));
    step(1'b0, 4'b0000);
    n_chk++;
    if (exp_m.size() == 0 && exp_l.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain actual=%0d required=0", exp_m.size() + exp_l.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/piso_4bit.md
Name: piso_4bit

Overview:
- Parallel-in serial-out shift register. Captures a WIDTH-bit parallel word and shifts it out one bit per clock, MSB first by default.
- Free-running: a new word is captured automatically every WIDTH cycles. There is no load input.
- Sits at a serializer boundary, for example feeding a 1-bit link or output pin from a parallel datapath.

Parameters:
- WIDTH, 4, parallel word width in bits (≥2).
- LSB_FIRST, 0, shift order: 0 sends MSB first, 1 sends LSB first.

Ports:
- clock  input  1  rising-edge clock; all state is updated on this edge.
- reset  input  1  synchronous, active-high reset.
- parallel_in  input  WIDTH  word to serialize; sampled only on load edges.
- serial_out  output  1  serial data bit, driven from a register.
- word_start  output  1  high during the cycle in which serial_out carries the first bit of a word.

Behaviour:
- Interface: one clock (clock). reset is synchronous and active-high, sampled on the rising edge of clock.

State:
- sreg: WIDTH-bit shift register.
- bit_cnt: counts 0..WIDTH-1, ceil(log2(WIDTH)) bits wide.
- word_start: registered flag.

Reset (reset=1 at a rising edge):
- sreg is set to 0, bit_cnt to 0, word_start to 0.
- serial_out therefore reads 0 from the cycle after that edge.
- reset takes priority over every other action, including mid-word. The partial word is discarded and no bits are flushed.

Normal operation (reset=0 at a rising edge):
- Load edge (bit_cnt==0):
  - sreg <= parallel_in.
  - bit_cnt <= 1, wrapping to 0 if WIDTH==1 (not a supported configuration).
  - word_start <= 1.
- Shift edge (bit_cnt!=0):
  - MSB-first: sreg <= {sreg[WIDTH-2:0], 1'b0}.
  - LSB-first: sreg <= {1'b0, sreg[WIDTH-1:1]}.
  - bit_cnt <= bit_cnt+1, wrapping from WIDTH-1 to 0.
  - word_start <= 0.

Output:
- serial_out = sreg[WIDTH-1] when MSB-first, sreg[0] when LSB-first. It is a direct register output with no combinational path from parallel_in.

Latency and timing:
- Bit k of a word (k=0 is the first bit sent) appears k cycles after the load edge, and is valid for exactly one cycle.
- The first bit is visible immediately after the load edge, so latency from sampling parallel_in to its first bit is 1 edge.
- The word period is WIDTH cycles, back-to-back with no idle gap.
- The next load edge occurs WIDTH edges after the previous one.

Boundary conditions:
- parallel_in changes between load edges: no effect on the word currently being shifted; the new value is taken at the next load edge.
- parallel_in changes on the load edge itself: the value present at that edge is captured.
- First edge after reset deasserts: always a load edge, because bit_cnt==0.
- Reset asserted for multiple cycles: outputs hold 0 throughout.
- Reset deasserted and re-asserted mid-word: outputs return to 0 on the next edge, and the next word starts cleanly.
- Zero fill: bits shifted in are 0. After a load they are never visible, because reload occurs before they reach the output.

Test Plan:
- Reset: hold reset=1 for 1+ edges with parallel_in=4'b1111 -> serial_out=0, word_start=0 after each edge.
- Basic MSB-first: clock period 10ns. Assert reset until t=10, then parallel_in=4'b1011. Edges at 15/25/35/45 ns -> serial_out 1,0,1,1. word_start=1 only after the 15ns edge.
- Back-to-back words: parallel_in=4'b1011 for the first word, changed to 4'b0110 at mid-word -> first word still 1,0,1,1, then 0,1,1,0 with no gap. word_start pulses every 4 cycles.
- Reset mid-word: after 2 bits of 4'b1011 (1,0), assert reset for one edge -> serial_out=0. After release, the first edge reloads the current parallel_in and restarts at its MSB.
- All-zeros and all-ones: 4'b0000 -> four 0s; 4'b1111 -> four 1s. word_start keeps its 4-cycle cadence regardless of data.
- LSB_FIRST=1 with parallel_in=4'b1011 -> serial_out 1,1,0,1.
